// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and constants for the alarm-clock adjust-mode logic
// Contents: mode_t (RUN/ADJ state encoding), DEFAULT_N_FIELDS (TH, TM, AH, AM).
package clock_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ADJ = 1'b1
  } mode_t;

  localparam int DEFAULT_N_FIELDS = 4;

  // Bit positions of the buttons inside the edge-detector vector.
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_CENTER = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 4;
  localparam int N_BTNS     = 5;

endpackage

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - rising-edge detector for a vector of debounced button levels
// Ports: clk, rst_n (async active-low), btn[W-1:0] levels in,
//        rise[W-1:0] one-cycle rising-edge flags out (combinational from btn).
module btn_edge_detect #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] btn_q;
  logic         armed_q;

  // armed_q masks the first cycle after reset release, so a button that is
  // already held when reset lifts is absorbed into btn_q without an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn;
      armed_q <= 1'b1;
    end
  end

  assign rise = btn & ~btn_q & {W{armed_q}};

endmodule

// File: rtl/adjust_mode_ctrl.sv
// rtl/adjust_mode_ctrl.sv - RUN/ADJ field selector with inc/dec hold-repeat and inactivity timeout
// Ports: clk, rst_n (async active-low), tick (time-base strobe),
//        btn_left/right/center/up/down (debounced levels),
//        adjust (1 in ADJ), en (one-hot field enable, MSB = field 0), field_idx,
//        inc/dec (one-cycle adjust pulses), timeout_evt (one-cycle auto-return pulse).
module adjust_mode_ctrl
  import clock_pkg::*;
#(
  parameter int N_FIELDS      = DEFAULT_N_FIELDS,
  parameter int TIMEOUT_TICKS = 10,
  parameter int HOLD_TICKS    = 2,
  parameter int IDX_W         = $clog2(N_FIELDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_center,
  input  logic                btn_up,
  input  logic                btn_down,
  output logic                adjust,
  output logic [N_FIELDS-1:0] en,
  output logic [IDX_W-1:0]    field_idx,
  output logic                inc,
  output logic                dec,
  output logic                timeout_evt
);

  localparam int TO_W   = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_FIELDS - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [TO_W-1:0]     TO_LAST   = (TIMEOUT_TICKS > 0) ? TO_W'(TIMEOUT_TICKS - 1) : '0;
  localparam logic [N_FIELDS-1:0] EN_RST    = {1'b1, {(N_FIELDS-1){1'b0}}};

  logic [N_BTNS-1:0] btn_vec;
  logic [N_BTNS-1:0] rise;

  assign btn_vec = {btn_down, btn_up, btn_center, btn_right, btn_left};

  btn_edge_detect #(
    .W(N_BTNS)
  ) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_vec),
    .rise (rise)
  );

  mode_t               state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TO_W-1:0]     inact_q, inact_d;
  logic [N_FIELDS-1:0] en_q, en_d;
  logic                adjust_q, adjust_d;
  logic                inc_q, inc_d;
  logic                dec_q, dec_d;
  logic                to_q, to_d;

  logic up_only, dn_only, hold_hit, any_rise, timeout_now;

  assign up_only  = btn_up & ~btn_down;
  assign dn_only  = btn_down & ~btn_up;
  // The tick that takes the hold count to HOLD_TICKS, and every tick after
  // it while saturated, produces a repeat pulse.
  assign hold_hit = tick && (hold_q >= HOLD_LAST);
  assign any_rise = |rise;
  // Any edge or held up/down in this cycle keeps the controller awake, so a
  // button edge on the final tick overrides the timeout.
  assign timeout_now = (TIMEOUT_TICKS > 0) && tick && !any_rise && !btn_up && !btn_down
                       && (inact_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    inact_d = inact_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    to_d    = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Counters rest at zero in RUN so entering ADJ starts fresh.
        hold_d  = '0;
        inact_d = '0;
        if (rise[BTN_CENTER]) begin
          state_d = ST_ADJ;
          idx_d   = '0;
        end
      end

      default: begin
        if (up_only || dn_only) begin
          if (tick && (hold_q != HOLD_MAX)) hold_d = hold_q + 1'b1;
        end else begin
          hold_d = '0;
        end
        inc_d = up_only & (rise[BTN_UP]   | hold_hit);
        dec_d = dn_only & (rise[BTN_DOWN] | hold_hit);

        if (any_rise || btn_up || btn_down) begin
          inact_d = '0;
        end else if (tick && (TIMEOUT_TICKS > 0)) begin
          inact_d = inact_q + 1'b1;
        end

        if (rise[BTN_RIGHT]) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else if (rise[BTN_LEFT]) begin
          idx_d = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
        end else if (rise[BTN_CENTER] || timeout_now) begin
          state_d = ST_RUN;
          idx_d   = '0;
          inc_d   = 1'b0;
          dec_d   = 1'b0;
          hold_d  = '0;
          inact_d = '0;
          to_d    = timeout_now;
        end
      end
    endcase
  end

  always_comb begin
    en_d     = '0;
    adjust_d = (state_d == ST_ADJ);
    if (state_d == ST_ADJ) en_d[LAST_IDX - idx_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ADJ;
      idx_q    <= '0;
      hold_q   <= '0;
      inact_q  <= '0;
      en_q     <= EN_RST;
      adjust_q <= 1'b1;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      inact_q  <= inact_d;
      en_q     <= en_d;
      adjust_q <= adjust_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      to_q     <= to_d;
    end
  end

  assign adjust      = adjust_q;
  assign en          = en_q;
  assign field_idx   = idx_q;
  assign inc         = inc_q;
  assign dec         = dec_q;
  assign timeout_evt = to_q;

endmodule

// File: tb/tb_adjust_mode_ctrl.sv
// tb/tb_adjust_mode_ctrl.sv - self-checking bench for adjust_mode_ctrl
module tb_adjust_mode_ctrl;

  localparam int N = 4;
  localparam int T = 10;
  localparam int H = 2;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_C = 5'b00100;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b10000;
  localparam logic [4:0] B_0 = 5'b00000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0;
  logic       adjust;
  logic [3:0] en;
  logic [1:0] field_idx;
  logic       inc, dec, timeout_evt;

  always #5 clk = ~clk;

  adjust_mode_ctrl #(
    .N_FIELDS     (N),
    .TIMEOUT_TICKS(T),
    .HOLD_TICKS   (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .adjust     (adjust),
    .en         (en),
    .field_idx  (field_idx),
    .inc        (inc),
    .dec        (dec),
    .timeout_evt(timeout_evt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cnt_pulse = 0;
  int cnt_to = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode flag, field number and two plain tick counters.
  bit       m_adj;
  int       m_idx, m_hold, m_inact;
  bit       m_inc, m_dec, m_to;
  bit [4:0] m_prev;
  bit       m_armed;

  function automatic void model_reset();
    m_adj = 1'b1; m_idx = 0; m_hold = 0; m_inact = 0;
    m_inc = 1'b0; m_dec = 1'b0; m_to = 1'b0;
    m_prev = '0; m_armed = 1'b0;
  endfunction

  function automatic void model_step(input bit [4:0] b, input bit t);
    bit [4:0] r;
    bit up, dn, leave;
    r = b & ~m_prev & {5{m_armed}};
    up = b[3]; dn = b[4]; leave = 1'b0;
    m_inc = 1'b0; m_dec = 1'b0; m_to = 1'b0;
    if (!m_adj) begin
      if (r[2]) begin
        m_adj = 1'b1; m_idx = 0; m_hold = 0; m_inact = 0;
      end
    end else begin
      if (up != dn) begin
        if (t && m_hold < H) m_hold++;
        m_inc = up && (r[3] || (t && m_hold >= H));
        m_dec = dn && (r[4] || (t && m_hold >= H));
      end else begin
        m_hold = 0;
      end
      if (r != 0 || up || dn) m_inact = 0;
      else if (t) m_inact++;
      if (r[1])      m_idx = (m_idx + 1) % N;
      else if (r[0]) m_idx = (m_idx + N - 1) % N;
      else if (r[2]) leave = 1'b1;
      if (!leave && T > 0 && m_inact >= T) begin
        leave = 1'b1; m_to = 1'b1;
      end
      if (leave) begin
        m_adj = 1'b0; m_idx = 0; m_inc = 1'b0; m_dec = 1'b0; m_hold = 0; m_inact = 0;
      end
    end
    m_prev = b; m_armed = 1'b1;
  endfunction

  task automatic compare_all();
    logic [31:0] exp_en;
    exp_en = m_adj ? (32'd1 << (N - 1 - m_idx)) : 32'd0;
    check("adjust", {31'd0, adjust}, {31'd0, m_adj});
    check("en", {28'd0, en}, exp_en);
    check("field_idx", {30'd0, field_idx}, m_adj ? 32'(m_idx) : 32'd0);
    check("inc", {31'd0, inc}, {31'd0, m_inc});
    check("dec", {31'd0, dec}, {31'd0, m_dec});
    check("timeout_evt", {31'd0, timeout_evt}, {31'd0, m_to});
  endtask

  task automatic step(input logic [4:0] b, input logic t);
    {btn_down, btn_up, btn_center, btn_right, btn_left} = b;
    tick = t;
    model_step(b, t);
    @(posedge clk);
    #1;
    compare_all();
    if (inc || dec) cnt_pulse++;
    if (timeout_evt) cnt_to++;
  endtask

  task automatic press(input logic [4:0] b);
    step(b, 1'b0);
    step(B_0, 1'b0);
  endtask

  logic [3:0] right_seq [4];
  logic [4:0] cur;

  initial begin
    right_seq[0] = 4'b0100; right_seq[1] = 4'b0010;
    right_seq[2] = 4'b0001; right_seq[3] = 4'b1000;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    check("rst_adjust", {31'd0, adjust}, 32'd1);
    check("rst_en", {28'd0, en}, 32'h8);
    check("rst_idx", {30'd0, field_idx}, 32'd0);
    check("rst_pulses", {29'd0, inc, dec, timeout_evt}, 32'd0);

    repeat (20) step(B_0, 1'b0);
    check("idle_en", {28'd0, en}, 32'h8);

    for (int i = 0; i < 4; i++) begin
      press(B_R);
      check("right_wrap_en", {28'd0, en}, {28'd0, right_seq[i]});
    end
    press(B_L);
    check("left_wrap_en", {28'd0, en}, 32'h1);
    check("left_wrap_idx", {30'd0, field_idx}, 32'd3);

    press(B_C);
    check("center_run", {27'd0, adjust, en}, 32'h0);
    press(B_C);
    check("center_adj", {27'd0, adjust, en}, 32'h18);
    press(B_R);
    press(B_R | B_C);
    check("right_beats_center", {29'd0, adjust, field_idx}, 32'h6);

    cnt_pulse = 0;
    press(B_U);
    check("single_inc", cnt_pulse, 32'd1);

    cnt_pulse = 0;
    step(B_U, 1'b0);
    repeat (5) begin
      step(B_U, 1'b1);
      step(B_U, 1'b0);
    end
    step(B_0, 1'b0);
    check("hold_repeat", cnt_pulse, 32'd5);

    cnt_pulse = 0;
    step(B_U | B_D, 1'b0);
    repeat (4) begin
      step(B_U | B_D, 1'b1);
      step(B_U | B_D, 1'b0);
    end
    step(B_0, 1'b0);
    check("both_held", cnt_pulse, 32'd0);

    cnt_to = 0;
    repeat (9) step(B_0, 1'b1);
    check("before_timeout", {31'd0, adjust}, 32'd1);
    step(B_0, 1'b1);
    check("timeout_run", {27'd0, adjust, en}, 32'h0);
    check("timeout_once", cnt_to, 32'd1);

    press(B_C);
    cnt_to = 0;
    repeat (9) step(B_0, 1'b1);
    step(B_R, 1'b1);
    check("edge_beats_timeout", {29'd0, adjust, field_idx}, 32'h5);
    check("no_timeout", cnt_to, 32'd0);
    step(B_0, 1'b0);

    press(B_R);
    press(B_R);
    step(B_U, 1'b0);
    step(B_U, 1'b1);
    step(B_U, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_adjust", {31'd0, adjust}, 32'd1);
    check("async_rst_en", {28'd0, en}, 32'h8);
    check("async_rst_idx", {30'd0, field_idx}, 32'd0);
    check("async_rst_pulses", {29'd0, inc, dec, timeout_evt}, 32'd0);
    {btn_down, btn_up, btn_center, btn_right, btn_left} = B_0;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    cur = B_0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 7) == 0) cur[k] = ~cur[k];
      end
      step(cur, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
